// File: rtl/act_sram_loader_pkg.sv
// Shared types and helpers for the activation SRAM loader.
// Holds the FSM encoding, bank/word geometry and the space-to-depth act placement.
// Pure declarations; no logic of its own.
package act_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_LAST = 2'd2
   } state_t;

   localparam int NUM_BANKS     = 4;
   localparam int ACTS_PER_WORD = 16;

   // Act slot for a pixel: channel = {row[0],col[0]}, 2x2 position = {row[1],col[1]},
   // index = 15 - (4*channel + position), which is 15 - {channel, position}.
   function automatic logic [3:0] act_idx(input logic [1:0] row_lo, input logic [1:0] col_lo);
      logic [1:0] ch;
      logic [1:0] pos;
      ch  = {row_lo[0], col_lo[0]};
      pos = {row_lo[1], col_lo[1]};
      return 4'd15 - {ch, pos};
   endfunction

   // Active-low mask for the four acts a group of pixels from one row writes.
   function automatic logic [ACTS_PER_WORD-1:0] act_mask(input logic [1:0] row_lo);
      logic [ACTS_PER_WORD-1:0] m;
      m = '1;
      for (int k = 0; k < 4; k++) begin
         m[act_idx(row_lo, 2'(k))] = 1'b0;
      end
      return m;
   endfunction

endpackage

// File: rtl/act_sram_loader_if.sv
// Pixel stream into the loader: valid/ready with a last-pixel tag.
// No latency; pure wiring.
// Source holds valid/data/last until ready is seen high at a clock edge.
interface act_sram_loader_if #(
   parameter int BW_PER_ACT = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic [BW_PER_ACT-1:0] in_data;
   logic                  in_last;

   modport master (
      output in_valid,
      output in_data,
      output in_last,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  in_last,
      output in_ready
   );
endinterface

// File: rtl/act_sram_loader_pack4.sv
// Packs four same-row pixels into one 16-act space-to-depth SRAM word plus its mask.
// Combinational, zero latency.
// No handshake; the caller registers the result when it issues the write.
module act_pack4
   import act_loader_pkg::*;
#(
   parameter int BW_PER_ACT = 8
) (
   input  logic [BW_PER_ACT-1:0]               p0,
   input  logic [BW_PER_ACT-1:0]               p1,
   input  logic [BW_PER_ACT-1:0]               p2,
   input  logic [BW_PER_ACT-1:0]               p3,
   input  logic [1:0]                          row_lo,
   output logic [ACTS_PER_WORD*BW_PER_ACT-1:0] wdata,
   output logic [ACTS_PER_WORD-1:0]            mask
);

   // Drop each tap into its act slot; slots this group does not own stay zero.
   always_comb begin
      wdata = '0;
      mask  = act_mask(row_lo);
      wdata[act_idx(row_lo, 2'd0) * BW_PER_ACT +: BW_PER_ACT] = p0;
      wdata[act_idx(row_lo, 2'd1) * BW_PER_ACT +: BW_PER_ACT] = p1;
      wdata[act_idx(row_lo, 2'd2) * BW_PER_ACT +: BW_PER_ACT] = p2;
      wdata[act_idx(row_lo, 2'd3) * BW_PER_ACT +: BW_PER_ACT] = p3;
   end

endmodule

// File: rtl/act_sram_loader.sv
// Streams a raster IMG_H x IMG_W image into SRAM group A as space-to-depth words.
// One write per 4 accepted pixels, issued the cycle after the 4th pixel of a group.
// in_ready is high only while loading; in_valid low stalls counters and shift register.
module act_sram_loader
   import act_loader_pkg::*;
#(
   parameter int BW_PER_ACT = 8,
   parameter int IMG_W      = 28,
   parameter int IMG_H      = 28,
   parameter int ADDR_W     = 6,
   parameter int ROW_STRIDE = 4
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                start,
   input  logic [ADDR_W-1:0]                   base_addr,
   act_sram_loader_if.slave                    pix,
   output logic                                busy,
   output logic                                done,
   output logic                                err,
   output logic                                sram_wen_a0,
   output logic                                sram_wen_a1,
   output logic                                sram_wen_a2,
   output logic                                sram_wen_a3,
   output logic [ACTS_PER_WORD-1:0]            sram_bytemask_a,
   output logic [ADDR_W-1:0]                   sram_waddr_a,
   output logic [ACTS_PER_WORD*BW_PER_ACT-1:0] sram_wdata_a
);

   // One spare bit so row[2]/col[2] exist even for 4-pixel dimensions
   // and the row counter can step past the last row without wrapping.
   localparam int ROW_W = $clog2(IMG_H) + 1;
   localparam int COL_W = $clog2(IMG_W) + 1;

   state_t                              state_q, state_d;
   logic [ROW_W-1:0]                    row_q;
   logic [COL_W-1:0]                    col_q;
   logic [ADDR_W-1:0]                   base_q;
   // The three older pixels of the current group; the fourth is taken straight
   // from in_data so the word can be registered on the accepting edge.
   logic [2:0][BW_PER_ACT-1:0]          sr_q;
   logic [NUM_BANKS-1:0]                wen_q;
   logic [ACTS_PER_WORD-1:0]            mask_q;
   logic [ADDR_W-1:0]                   waddr_q;
   logic [ACTS_PER_WORD*BW_PER_ACT-1:0] wdata_q;

   logic                                start_go;
   logic                                accept;
   logic                                last_pix;
   logic                                grp_full;
   logic [1:0]                          bank_sel;
   logic [ADDR_W-1:0]                   waddr_d;
   logic [ACTS_PER_WORD*BW_PER_ACT-1:0] wdata_d;
   logic [ACTS_PER_WORD-1:0]            mask_d;

   assign pix.in_ready = (state_q == ST_LOAD);
   assign start_go     = start && (state_q == ST_IDLE);
   assign accept       = pix.in_valid && pix.in_ready;
   assign last_pix     = (row_q == ROW_W'(IMG_H - 1)) && (col_q == COL_W'(IMG_W - 1));
   assign grp_full     = accept && (col_q[1:0] == 2'b11);
   assign bank_sel     = {row_q[2], col_q[2]};
   assign waddr_d      = base_q
                       + ADDR_W'(row_q >> 3) * ADDR_W'(ROW_STRIDE)
                       + ADDR_W'(col_q >> 3);

   act_pack4 #(
      .BW_PER_ACT (BW_PER_ACT)
   ) u_pack (
      .p0     (sr_q[0]),
      .p1     (sr_q[1]),
      .p2     (sr_q[2]),
      .p3     (pix.in_data),
      .row_lo (row_q[1:0]),
      .wdata  (wdata_d),
      .mask   (mask_d)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next state: start opens a frame, the final pixel closes it, LAST lasts one cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_LOAD;
         ST_LOAD: if (accept && last_pix) state_d = ST_LAST;
         ST_LAST: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Raster position counters and the frame base address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_q  <= '0;
         col_q  <= '0;
         base_q <= '0;
      end else if (start_go) begin
         row_q  <= '0;
         col_q  <= '0;
         base_q <= base_addr;
      end else if (accept) begin
         if (col_q == COL_W'(IMG_W - 1)) begin
            col_q <= '0;
            row_q <= row_q + 1'b1;
         end else begin
            col_q <= col_q + 1'b1;
         end
      end
   end

   // Pixel shift register; oldest pixel of the group ends up in sr_q[0].
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      sr_q <= '0;
      else if (accept) sr_q <= {pix.in_data, sr_q[2:1]};
   end

   // Frame status: busy spans start to done, done pulses after LAST, err is sticky per frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         done <= 1'b0;
         err  <= 1'b0;
      end else begin
         done <= (state_q == ST_LAST);
         if (start_go)                 busy <= 1'b1;
         else if (state_q == ST_LAST)  busy <= 1'b0;
         if (start_go)                             err <= 1'b0;
         else if (accept && (pix.in_last != last_pix)) err <= 1'b1;
      end
   end

   // Write port: one bank strobes for a single cycle per completed group; the rest hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wen_q   <= '1;
         mask_q  <= '1;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         wen_q <= '1;
         if (grp_full) begin
            wen_q   <= ~(NUM_BANKS'(1) << bank_sel);
            mask_q  <= mask_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
         end
      end
   end

   assign sram_wen_a0     = wen_q[0];
   assign sram_wen_a1     = wen_q[1];
   assign sram_wen_a2     = wen_q[2];
   assign sram_wen_a3     = wen_q[3];
   assign sram_bytemask_a = mask_q;
   assign sram_waddr_a    = waddr_q;
   assign sram_wdata_a    = wdata_q;

endmodule

// File: tb/tb_act_sram_loader.sv
// Scoreboard bench for act_sram_loader at default parameters (28x28, 8-bit acts, 6-bit address).
// Stimulus pushes expected writes/frame results; a monitor pops and compares on each wen strobe and done.
// Covers reset values, directed words, stalls, back-to-back frames, in_last errors and mid-frame reset.
module tb_act_sram_loader;

   localparam int BW   = 8;
   localparam int W    = 28;
   localparam int H    = 28;
   localparam int AW   = 6;
   localparam int NPIX = W * H;
   localparam int NWR  = NPIX / 4;

   typedef struct {
      logic [1:0]   bank;
      logic [5:0]   addr;
      logic [15:0]  mask;
      logic [127:0] data;
   } wr_t;

   typedef struct {
      int  frame;
      int  widx;
      wr_t w;
   } dir_t;

   typedef struct {
      int   nwr;
      logic err;
   } frm_t;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           start;
   logic [AW-1:0]  base_addr;
   logic           busy, done, err;
   logic           wen0, wen1, wen2, wen3;
   logic [15:0]    mask;
   logic [AW-1:0]  waddr;
   logic [127:0]   wdata;

   wr_t  exp_q[$];
   dir_t dir_q[$];
   frm_t frm_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cur_frame = 0;

   always #5 clk = ~clk;

   act_sram_loader_if #(.BW_PER_ACT(BW)) pix ();

   act_sram_loader #(
      .BW_PER_ACT (BW),
      .IMG_W      (W),
      .IMG_H      (H),
      .ADDR_W     (AW),
      .ROW_STRIDE (4)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .base_addr       (base_addr),
      .pix             (pix.slave),
      .busy            (busy),
      .done            (done),
      .err             (err),
      .sram_wen_a0     (wen0),
      .sram_wen_a1     (wen1),
      .sram_wen_a2     (wen2),
      .sram_wen_a3     (wen3),
      .sram_bytemask_a (mask),
      .sram_waddr_a    (waddr),
      .sram_wdata_a    (wdata)
   );

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, got, want);
      end
   endtask

   task automatic bound_fail(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: bound expired at %0t", name, $time);
   endtask

   // Expected write for the group starting at (r, c0), pixel value (index+vofs)%256.
   function automatic wr_t model(input int base, input int r, input int c0, input int vofs);
      wr_t e;
      int  c, ch, pos, idx;
      e.bank = 2'(((r >> 2) & 1) * 2 + ((c0 >> 2) & 1));
      e.addr = 6'((base + (r / 8) * 4 + c0 / 8) % 64);
      e.mask = 16'hFFFF;
      e.data = '0;
      for (int k = 0; k < 4; k++) begin
         c   = c0 + k;
         ch  = (r % 2) * 2 + (c % 2);
         pos = ((r / 2) % 2) * 2 + ((c / 2) % 2);
         idx = 15 - 4 * ch - pos;
         e.data[idx*8 +: 8] = 8'((r * W + c + vofs) % 256);
         e.mask[idx]        = 1'b0;
      end
      return e;
   endfunction

   // Hand-specified write word: four (act index, value) pairs.
   function automatic wr_t hand(input logic [1:0] b, input logic [5:0] a, input logic [15:0] m,
                                input int i0, input int v0, input int i1, input int v1,
                                input int i2, input int v2, input int i3, input int v3);
      wr_t e;
      e.bank = b;
      e.addr = a;
      e.mask = m;
      e.data = '0;
      e.data[i0*8 +: 8] = 8'(v0);
      e.data[i1*8 +: 8] = 8'(v1);
      e.data[i2*8 +: 8] = 8'(v2);
      e.data[i3*8 +: 8] = 8'(v3);
      return e;
   endfunction

   function automatic dir_t mk_dir(input int fr, input int wi, input wr_t w);
      dir_t d;
      d.frame = fr;
      d.widx  = wi;
      d.w     = w;
      return d;
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_wen"},   {wen3, wen2, wen1, wen0}, 4'hF);
      chk({tag, "_mask"},  mask, 16'hFFFF);
      chk({tag, "_waddr"}, waddr, 0);
      chk({tag, "_wdata"}, wdata, 0);
      chk({tag, "_ready"}, pix.in_ready, 0);
      chk({tag, "_busy"},  busy, 0);
      chk({tag, "_done"},  done, 0);
      chk({tag, "_err"},   err, 0);
   endtask

   task automatic send_pix(input logic [7:0] d, input logic l, output bit ok);
      logic rdy;
      ok = 1'b0;
      pix.in_valid = 1'b1;
      pix.in_data  = d;
      pix.in_last  = l;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         rdy = pix.in_ready;
         @(posedge clk);
         #1;
         if (rdy) begin
            ok = 1'b1;
            break;
         end
      end
      pix.in_valid = 1'b0;
      pix.in_last  = 1'b0;
      if (!ok) bound_fail("pixel_accept");
   endtask

   task automatic send_frame(input int base, input int vofs, input bit stalls,
                             input int bad_last, input int stop_at);
      bit ok;
      ok = 1'b1;
      for (int i = 0; i < stop_at && ok; i++) begin
         if (stalls) begin
            repeat ($urandom_range(2)) begin
               @(posedge clk);
               #1;
            end
         end
         if ((i % W) % 4 == 0) exp_q.push_back(model(base, i / W, i % W, vofs));
         send_pix(8'((i + vofs) % 256), (i == NPIX - 1) || (i == bad_last), ok);
      end
   endtask

   task automatic do_start(input logic [AW-1:0] b, input logic exp_err);
      frm_t f;
      f.nwr = NWR;
      f.err = exp_err;
      frm_q.push_back(f);
      cur_frame++;
      start     = 1'b1;
      base_addr = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("start_busy", busy, 1);
      chk("start_err_clear", err, 0);
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int t = 0; t < 40; t++) begin
         @(posedge clk);
         #1;
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) bound_fail("wait_done");
   endtask

   // Monitor: pops one expected write per wen strobe and one frame result per done.
   initial begin : monitor
      bit         prev_low;
      int         wr_idx;
      int         mon_frame;
      logic [3:0] wen;
      wr_t        got;
      wr_t        e;
      frm_t       f;
      dir_t       d;
      prev_low  = 1'b0;
      wr_idx    = 0;
      mon_frame = 0;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n !== 1'b1) begin
            prev_low = 1'b0;
            continue;
         end
         wen = {wen3, wen2, wen1, wen0};
         if (done) begin
            if (frm_q.size() == 0) begin
               bound_fail("done_unexpected");
            end else begin
               f = frm_q.pop_front();
               chk("done_nwrites", wr_idx, f.nwr);
               chk("done_err", err, f.err);
               chk("done_after_write", prev_low, 1);
               chk("done_busy", busy, 0);
            end
         end
         if (wen != 4'hF) begin
            if (cur_frame != mon_frame) begin
               mon_frame = cur_frame;
               wr_idx    = 0;
            end
            chk("wen_onehot", 4 - $countones(wen), 1);
            chk("wen_single_cycle", prev_low, 0);
            got.bank = 2'd0;
            for (int b = 0; b < 4; b++) if (!wen[b]) got.bank = 2'(b);
            got.addr = waddr;
            got.mask = mask;
            got.data = wdata;
            if (exp_q.size() == 0) begin
               bound_fail("write_unexpected");
            end else begin
               e = exp_q.pop_front();
               chk("wr_bank", got.bank, e.bank);
               chk("wr_addr", got.addr, e.addr);
               chk("wr_mask", got.mask, e.mask);
               chk("wr_data", got.data, e.data);
            end
            if (dir_q.size() > 0 && dir_q[0].frame == mon_frame && dir_q[0].widx == wr_idx) begin
               d = dir_q.pop_front();
               chk("dir_bank", got.bank, d.w.bank);
               chk("dir_addr", got.addr, d.w.addr);
               chk("dir_mask", got.mask, d.w.mask);
               chk("dir_data", got.data, d.w.data);
            end
            wr_idx++;
            prev_low = 1'b1;
         end else begin
            prev_low = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin : stimulus
      rst_n        = 1'b0;
      start        = 1'b0;
      base_addr    = '0;
      pix.in_valid = 1'b0;
      pix.in_data  = '0;
      pix.in_last  = 1'b0;

      // Hand-computed words: (frame, write index) -> bank, addr, mask, acts.
      dir_q.push_back(mk_dir(1, 0,  hand(2'd0, 6'd0,  16'h33FF, 15, 0,   14, 2,   11, 1,   10, 3)));
      dir_q.push_back(mk_dir(1, 8,  hand(2'd1, 6'd0,  16'hFF33, 7,  32,  6,  34,  3,  33,  2,  35)));
      dir_q.push_back(mk_dir(1, 58, hand(2'd0, 6'd5,  16'h33FF, 15, 232, 14, 234, 11, 233, 10, 235)));
      dir_q.push_back(mk_dir(2, 58, hand(2'd0, 6'd1,  16'h33FF, 15, 232, 14, 234, 11, 233, 10, 235)));
      dir_q.push_back(mk_dir(5, 0,  hand(2'd0, 6'd20, 16'h33FF, 15, 0,   14, 2,   11, 1,   10, 3)));

      #12;
      chk_reset_vals("por");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Frame 1: base 0, no stalls.
      do_start(6'd0, 1'b0);
      send_frame(0, 0, 1'b0, -1, NPIX);
      wait_done();

      // Frame 2: start in the done cycle, base 60, random stalls.
      do_start(6'd60, 1'b0);
      send_frame(60, 0, 1'b1, -1, NPIX);
      wait_done();

      // Frame 3: immediate restart, in_last also raised on pixel 100.
      do_start(6'd0, 1'b1);
      send_frame(0, 7, 1'b0, 100, NPIX);
      wait_done();
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      chk("err_sticky", err, 1);
      chk("idle_busy", busy, 0);

      // Frame 4: start clears err; reset while pixel 400 is presented.
      do_start(6'd12, 1'b0);
      send_frame(12, 0, 1'b0, -1, 400);
      pix.in_valid = 1'b1;
      pix.in_data  = 8'(400);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      pix.in_valid = 1'b0;
      chk("midrst_pending_writes", exp_q.size(), 0);
      frm_q.delete();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end

      // Frame 5: fresh load after reset, base 20.
      do_start(6'd20, 1'b0);
      send_frame(20, 0, 1'b0, -1, NPIX);
      wait_done();
      repeat (4) begin
         @(posedge clk);
         #1;
      end

      chk("end_writes_left", exp_q.size(), 0);
      chk("end_directed_left", dir_q.size(), 0);
      chk("end_frames_left", frm_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
